// File: rtl/conv_pkg.sv
// Shared types and default layer constants for the convolution output-address controller.
// Optional lookahead output is enabled by defining CONV_ADDR_AHEAD_EN.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    localparam int DEF_IN_CH    = 4;
    localparam int DEF_OUT_CH   = 8;
    localparam int DEF_LANES    = 4;
    localparam int DEF_KSIZE    = 5;
    localparam int DEF_OUT_R    = 28;
    localparam int DEF_OUT_C    = 28;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_PIPE_DLY = 2;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_addr_delay.sv
// Fixed-latency valid+address shift register; the whole line freezes while hold is high.
module conv_addr_delay
    import conv_pkg::*;
#(
    parameter int DLY    = DEF_PIPE_DLY,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              any_valid
);

    logic [DLY-1:0]    vld_q;
    logic [ADDR_W-1:0] addr_q [DLY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                addr_q[i] <= '0;
            end
        end else if (!hold) begin
            vld_q[0]  <= in_valid;
            addr_q[0] <= in_addr;
            for (int i = 1; i < DLY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DLY-1];
    assign out_addr  = addr_q[DLY-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/conv_out_addr_gen.sv
// Output-address controller: counts MAC beats per neuron and emits one buffer write per neuron.
// Define CONV_ADDR_AHEAD_EN to add the neuron_rdy_ahead lookahead pulse.
module conv_out_addr_gen
    import conv_pkg::*;
#(
    parameter int IN_CH    = DEF_IN_CH,
    parameter int OUT_CH   = DEF_OUT_CH,
    parameter int LANES    = DEF_LANES,
    parameter int KSIZE    = DEF_KSIZE,
    parameter int OUT_R    = DEF_OUT_R,
    parameter int OUT_C    = DEF_OUT_C,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PIPE_DLY = DEF_PIPE_DLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mac_valid,
    output logic              mac_ready,
    output logic              neuron_rdy,
    output logic              plane_rdy,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
`ifdef CONV_ADDR_AHEAD_EN
    output logic              neuron_rdy_ahead,
`endif
    output logic [1:0]        state_dbg
);

    localparam int BEATS  = ((IN_CH + LANES - 1) / LANES) * KSIZE * KSIZE;
    localparam int PLANE  = OUT_R * OUT_C;
    localparam int GROUPS = (OUT_CH + LANES - 1) / LANES;
    localparam int BEAT_W = cnt_w(BEATS);
    localparam int PIX_W  = cnt_w(PLANE);
    localparam int GRP_W  = cnt_w(GROUPS);

    if (64'(GROUPS) * 64'(PLANE) > (64'd1 << ADDR_W)) begin : g_chk_addr_w
        $error("conv_out_addr_gen: GROUPS*PLANE does not fit in ADDR_W");
    end
    if (PIPE_DLY < 1) begin : g_chk_pipe
        $error("conv_out_addr_gen: PIPE_DLY must be at least 1");
    end
`ifdef CONV_ADDR_AHEAD_EN
    if (BEATS < 2) begin : g_chk_ahead
        $error("conv_out_addr_gen: lookahead needs at least two beats per neuron");
    end
`endif

    conv_state_t       state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [GRP_W-1:0]  grp_cnt;

    logic              blocked;
    logic              accept;
    logic              beat_term;
    logic              pix_term;
    logic              grp_term;
    logic              last_beat;
    logic              pipe_any;
    logic [ADDR_W-1:0] cur_addr;

    // Handshakes: a beat transfers when mac_valid && mac_ready, a write when
    // wr_valid && wr_ready; an offered write keeps wr_addr stable until taken.
    assign blocked   = wr_valid && !wr_ready;
    assign mac_ready = (state == ST_RUN) && !blocked;
    assign accept    = mac_valid && mac_ready;

    assign beat_term = (beat_cnt == BEAT_W'(BEATS - 1));
    assign pix_term  = (pix_cnt == PIX_W'(PLANE - 1));
    assign grp_term  = (grp_cnt == GRP_W'(GROUPS - 1));

    always_comb begin
        neuron_rdy = 1'b0;
        plane_rdy  = 1'b0;
        last_beat  = 1'b0;
        neuron_rdy = accept && beat_term;
        plane_rdy  = neuron_rdy && pix_term;
        last_beat  = plane_rdy && grp_term;
    end

`ifdef CONV_ADDR_AHEAD_EN
    assign neuron_rdy_ahead = accept && (beat_cnt == BEAT_W'(BEATS - 2));
`endif

    // Word address = group * PLANE + pixel within the plane.
    assign cur_addr = ADDR_W'(grp_cnt) * ADDR_W'(PLANE) + ADDR_W'(pix_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            pix_cnt  <= '0;
            grp_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        pix_cnt  <= '0;
                        grp_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        beat_cnt <= beat_term ? '0 : beat_cnt + 1'b1;
                        if (neuron_rdy) begin
                            pix_cnt <= pix_term ? '0 : pix_cnt + 1'b1;
                        end
                        if (plane_rdy) begin
                            grp_cnt <= grp_term ? '0 : grp_cnt + 1'b1;
                        end
                        if (last_beat) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last address is still travelling; wait until it has been written.
                    if (!pipe_any) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

    conv_addr_delay #(
        .DLY    (PIPE_DLY),
        .ADDR_W (ADDR_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .hold      (blocked),
        .in_valid  (neuron_rdy),
        .in_addr   (cur_addr),
        .out_valid (wr_valid),
        .out_addr  (wr_addr),
        .any_valid (pipe_any)
    );

endmodule

// File: tb/tb_conv_out_addr_gen.sv
// Scoreboard bench for conv_out_addr_gen with default parameters.
module tb_conv_out_addr_gen;

    localparam int BEATS  = 25;
    localparam int PLANE  = 784;
    localparam int GROUPS = 2;
    localparam int NWR    = GROUPS * PLANE;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mac_valid;
    logic        mac_ready;
    logic        neuron_rdy;
    logic        plane_rdy;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;
`ifdef CONV_ADDR_AHEAD_EN
    logic        neuron_rdy_ahead;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    conv_out_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .neuron_rdy (neuron_rdy),
        .plane_rdy  (plane_rdy),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done),
`ifdef CONV_ADDR_AHEAD_EN
        .neuron_rdy_ahead (neuron_rdy_ahead),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_a;
    int          mdl_beat = 0;
    int          mdl_pix  = 0;
    int          mdl_grp  = 0;
    int          wr_cnt   = 0;
    int          nr_cnt   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    int          t_nr0    = -1;
    int          t_wv0    = -1;
    bit          prev_blk = 1'b0;
    logic [15:0] prev_addr;
    bit          acc, enr, epr, eah;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic model_clear();
        exp_q.delete();
        mdl_beat = 0;
        mdl_pix  = 0;
        mdl_grp  = 0;
        prev_blk = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            acc = mac_valid && mac_ready;
            enr = acc && (mdl_beat == BEATS - 1);
            epr = enr && (mdl_pix == PLANE - 1);
            eah = acc && (mdl_beat == BEATS - 2);
            if (enr || neuron_rdy) check("neuron_rdy", 32'(neuron_rdy), 32'(enr));
            if (epr || plane_rdy)  check("plane_rdy", 32'(plane_rdy), 32'(epr));
`ifdef CONV_ADDR_AHEAD_EN
            if (eah || neuron_rdy_ahead) check("neuron_rdy_ahead", 32'(neuron_rdy_ahead), 32'(eah));
`endif
            if (enr) begin
                if (t_nr0 < 0) t_nr0 = cyc;
                exp_q.push_back(16'(mdl_grp * PLANE + mdl_pix));
                nr_cnt++;
            end
            if (acc) begin
                if (mdl_beat == BEATS - 1) begin
                    mdl_beat = 0;
                    if (mdl_pix == PLANE - 1) begin
                        mdl_pix = 0;
                        mdl_grp = (mdl_grp == GROUPS - 1) ? 0 : mdl_grp + 1;
                    end else begin
                        mdl_pix++;
                    end
                end else begin
                    mdl_beat++;
                end
            end
            if (wr_valid && t_wv0 < 0) t_wv0 = cyc;
            if (wr_valid && !wr_ready) begin
                check("blocked_mac_ready", 32'(mac_ready), 32'd0);
                if (prev_blk) check("held_wr_addr", 32'(wr_addr), 32'(prev_addr));
                prev_blk  = 1'b1;
                prev_addr = wr_addr;
            end else begin
                prev_blk = 1'b0;
            end
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    fail_note("spurious_write");
                end else begin
                    exp_a = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(exp_a));
                end
                wr_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- driver ----------------
    int bp_at[3] = '{60, 3000, 20000};
    int bp_idx   = 0;
    int bp_left  = 0;
    int wr_base;
    bit finished;

    task automatic drive_wr_ready(input int n);
        if (bp_left > 0) begin
            wr_ready = 1'b0;
            bp_left--;
        end else begin
            wr_ready = 1'b1;
            if (bp_idx < 3 && n >= bp_at[bp_idx] && wr_valid) begin
                wr_ready = 1'b0;
                bp_left  = 4;
                bp_idx++;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mac_valid = 1'b0;
        wr_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mac_ready", 32'(mac_ready), 32'd0);
        check("rst_neuron_rdy", 32'(neuron_rdy), 32'd0);
        check("rst_plane_rdy", 32'(plane_rdy), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;

        // Full layer: solid beats first, then random gaps, stalls and a stray start.
        pulse_start();
        check("busy_rise", 32'(busy), 32'd1);
        finished = 1'b0;
        for (int n = 0; n < 70000 && !finished; n++) begin
            mac_valid = (n < 40) ? 1'b1 : ($urandom_range(0, 7) != 0);
            start     = (n == 500);
            drive_wr_ready(n);
            @(posedge clk); #1;
            if (n == 501) check("busy_after_stray_start", 32'(busy), 32'd1);
            if (done_cnt > 0) finished = 1'b1;
        end
        mac_valid = 1'b0;
        start     = 1'b0;
        wr_ready  = 1'b1;
        if (!finished) fail_note("layer_done_timeout");
        repeat (5) @(posedge clk);
        #1;
        check("first_latency", 32'(t_wv0 - t_nr0), 32'd2);
        check("write_count", 32'(wr_cnt), 32'(NWR));
        check("neuron_count", 32'(nr_cnt), 32'(NWR));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("state_idle", 32'(state_dbg), 32'd0);
        check("bp_events", 32'(bp_idx), 32'd3);

        // Second layer interrupted by reset mid-plane.
        pulse_start();
        mac_valid = 1'b1;
        finished  = 1'b0;
        for (int n = 0; n < 20000 && !finished; n++) begin
            @(posedge clk); #1;
            if (mdl_pix == 300) finished = 1'b1;
        end
        if (!finished) fail_note("pix300_timeout");
        rst = 1'b1;
        #1;
        check("midrst_mac_ready", 32'(mac_ready), 32'd0);
        check("midrst_neuron_rdy", 32'(neuron_rdy), 32'd0);
        check("midrst_wr_valid", 32'(wr_valid), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
        mac_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Restart: the first writes must come from address 0 again.
        wr_base = wr_cnt;
        pulse_start();
        mac_valid = 1'b1;
        finished  = 1'b0;
        for (int n = 0; n < 500 && !finished; n++) begin
            @(posedge clk); #1;
            if (wr_cnt >= wr_base + 3) finished = 1'b1;
        end
        if (!finished) fail_note("restart_write_timeout");
        check("restart_writes", 32'(wr_cnt - wr_base), 32'd3);
        mac_valid = 1'b0;
        rst       = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
